uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per bit period; legal range is even values 4..4096.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port serial_in  input  1  asynchronous UART line: idle high, 1 start (0), 8 data LSB first, 1 stop (1).
REQ-005 SHALL have port data_read  input  1  consumer acknowledge of the held byte.
REQ-006 SHALL have port data_out  output  8  last correctly framed byte.
REQ-007 SHALL have port data_valid  output  1  data_out holds an unacknowledged byte.
REQ-008 SHALL have port framing_err  output  1  last frame had stop bit = 0.
REQ-009 SHALL have port overrun_err  output  1  sticky flag: a byte was lost because data_valid was still set.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass serial_in through a 2-flop synchronizer; sync flops reset to 1; all FSM decisions use the synchronized value (rx).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH using a cycle counter (cnt) and a 3-bit bit index.
REQ-013 SHALL, in IDLE, move to START with cnt=0 in the cycle after rx is first seen 0.
REQ-014 SHALL, in START, sample rx when cnt = CLKS_PER_BIT/2-1: rx=0 -> DATA with cnt=0 and index=0; rx=1 -> IDLE (glitch rejected, no flags change).
REQ-015 SHALL, in DATA, sample rx when cnt = CLKS_PER_BIT-1, shift it into bit 7 of the shift register (right shift, LSB first), reset cnt, and increment index.
REQ-016 SHALL, after the 8th data sample, move to STOP.
REQ-017 SHALL, in STOP, sample rx when cnt = CLKS_PER_BIT-1.
REQ-018 SHALL, if the stop sample is 1: clear framing_err, deliver the byte per REQ-020/021, and go to IDLE.
REQ-019 SHALL, if the stop sample is 0: set framing_err, leave data_out/data_valid unchanged, and go to WAIT_HIGH; WAIT_HIGH exits to IDLE only once rx=1 (break condition).
REQ-020 SHALL, on delivery with data_valid=0 or data_read=1 in that cycle: load data_out and set data_valid=1 in the next cycle; delivery takes priority over the acknowledge.
REQ-021 SHALL, on delivery with data_valid=1 and data_read=0: discard the new byte, keep data_out, and set overrun_err.
REQ-022 SHALL clear data_valid in the cycle after data_read=1 while data_valid=1, unless REQ-020 applies; data_read with data_valid=0 SHALL have no effect on data_valid.
REQ-023 SHALL clear overrun_err on data_read=1, except that a set in the same cycle wins.
REQ-024 SHALL drive busy combinationally as state != IDLE.
REQ-025 SHALL have a count of 8 data bits per frame, with no parity.

Reset
REQ-026 SHALL, on rst=1 at any time (including mid-frame), immediately force: state IDLE, cnt 0, index 0, shift register 0, data_out 0x00, data_valid 0, framing_err 0, overrun_err 0, busy 0, sync flops 1.
REQ-027 SHALL produce no data_valid for a frame interrupted by reset; after rst falls, SHALL accept the next start bit normally.

Verification
REQ-028 SHALL cover a clean frame: CLKS_PER_BIT=16, send 0xA5 -> data_out=0xA5, data_valid=1 between 150 and 156 cycles after the start edge, framing_err=0.
REQ-029 SHALL cover glitch rejection: serial_in low for 5 cycles then high -> FSM returns to IDLE, data_valid stays 0, busy pulses, no flags set.
REQ-030 SHALL cover a framing error: send 0x3C with stop=0, held low for 40 cycles -> framing_err=1, data_valid=0, busy stays high until the line returns high; a following good 0x3C -> framing_err=0, data_out=0x3C.
REQ-031 SHALL cover overrun: send 0x11 then 0x22 with no data_read -> data_out=0x11, overrun_err=1; a data_read pulse -> data_valid=0 and overrun_err=0.
REQ-032 SHALL cover simultaneous events: data_read asserted in the delivery cycle of 0x55 while 0x11 is held -> data_out=0x55, data_valid=1, overrun_err=0.
REQ-033 SHALL cover mid-frame reset: assert rst during data bit 4 of 0xFF -> all outputs return to reset values immediately; a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with byte handshake, framing and overrun flags
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic r_sync1, r_sync2;
  logic w_rx, w_deliver, w_frame_bad, w_accept;
  assign w_rx = r_sync2;
  assign busy = r_state != IDLE;
  assign w_accept = !data_valid || data_read;
  // Two-flop synchronizer for the asynchronous line; idles high so reset looks like an idle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end
  // FSM, bit-period counter, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end
  // Next-state: start bit checked at mid-bit, data and stop bits one full period later each
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) w_state_nxt = START;
      end
      START: if (r_cnt == HALF) begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_state_nxt = w_rx ? IDLE : DATA;
      end
      DATA: if (r_cnt == FULL) begin
        w_cnt_nxt   = '0;
        w_shift_nxt = {w_rx, r_shift[7:1]};
        w_idx_nxt   = r_idx + 3'd1;
        if (r_idx == 3'd7) w_state_nxt = STOP;
      end
      STOP: if (r_cnt == FULL) begin
        w_cnt_nxt   = '0;
        w_deliver   = w_rx;
        w_frame_bad = !w_rx;
        w_state_nxt = w_rx ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // Output holding register: a new byte beats a same-cycle acknowledge, a held byte beats a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (w_deliver && w_accept) begin
        data_out   <= r_shift;
        data_valid <= 1'b1;
      end else if (data_read) data_valid <= 1'b0;
      if (w_deliver && !w_accept) overrun_err <= 1'b1;
      else if (data_read) overrun_err <= 1'b0;
      if (w_frame_bad) framing_err <= 1'b1;
      else if (w_deliver) framing_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven frames plus hand-written corner sequences, byte scoreboard
module tb_uart_receiver;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1, data_read = 1'b0;
  logic [7:0] data_out;
  logic data_valid, framing_err, overrun_err, busy;
  int total = 0, passed = 0;
  logic [7:0] sb[$];
  logic m_valid = 1'b0;
  typedef struct {
    logic [7:0] b;
    logic stop;
    logic ack;
    logic exp_valid;
    logic exp_ferr;
    logic exp_oerr;
  } vec_t;
  vec_t tbl[8];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .data_read(data_read),
    .data_out(data_out), .data_valid(data_valid), .framing_err(framing_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
    serial_in = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      cyc(CPB);
    end
    serial_in = stop;
    cyc(hold);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", busy, 0);
    cyc(4);
  endtask

  task automatic expect_good(input logic [7:0] b);
    if (!m_valid) begin
      sb.push_back(b);
      m_valid = 1'b1;
    end
  endtask

  task automatic check_front(input string name);
    if (sb.size() == 0) chk({name, "_sb_empty"}, 1, 0);
    else chk(name, data_out, sb[0]);
  endtask

  task automatic ack();
    data_read = 1'b1;
    cyc(1);
    data_read = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    m_valid = 1'b0;
    chk("ack_valid", data_valid, 0);
    chk("ack_oerr", overrun_err, 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_oerr", overrun_err, 0);
    chk("rst_busy", busy, 0);
    serial_in = 1'b0;
    cyc(5);
    serial_in = 1'b1;
    chk("glitch_busy", busy, 1);
    cyc(15);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_ferr", framing_err, 0);
    chk("glitch_oerr", overrun_err, 0);
    expect_good(8'hA5);
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, CPB);
      begin
        do begin
          cyc(1);
          n++;
        end while (!data_valid && n < 300);
      end
    join
    total++;
    if (n < 150 || n > 156) $display("FAIL latency: got %0d cycles required 150..156", n);
    else passed++;
    wait_idle();
    check_front("a5_data");
    chk("a5_ferr", framing_err, 0);
    ack();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].stop) expect_good(tbl[i].b);
      send_frame(tbl[i].b, tbl[i].stop, tbl[i].stop ? CPB : 40);
      if (!tbl[i].stop) begin
        chk($sformatf("v%0d_busy_low", i), busy, 1);
        serial_in = 1'b1;
      end
      wait_idle();
      chk($sformatf("v%0d_valid", i), data_valid, tbl[i].exp_valid);
      chk($sformatf("v%0d_ferr", i), framing_err, tbl[i].exp_ferr);
      chk($sformatf("v%0d_oerr", i), overrun_err, tbl[i].exp_oerr);
      if (tbl[i].exp_valid) check_front($sformatf("v%0d_data", i));
      if (tbl[i].ack) ack();
    end
    expect_good(8'h11);
    send_frame(8'h11, 1'b1, CPB);
    wait_idle();
    check_front("sim_pre_data");
    chk("sim_pre_valid", data_valid, 1);
    fork
      send_frame(8'h55, 1'b1, CPB);
      begin
        cyc(154);
        data_read = 1'b1;
        cyc(1);
        data_read = 1'b0;
      end
    join
    void'(sb.pop_front());
    m_valid = 1'b0;
    expect_good(8'h55);
    wait_idle();
    check_front("sim_data");
    chk("sim_valid", data_valid, 1);
    chk("sim_oerr", overrun_err, 0);
    fork
      send_frame(8'hFF, 1'b1, CPB);
      begin
        cyc(88);
        chk("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_data_out", data_out, 8'h00);
        chk("mid_valid", data_valid, 0);
        chk("mid_ferr", framing_err, 0);
        chk("mid_oerr", overrun_err, 0);
        chk("mid_busy", busy, 0);
      end
    join
    sb.delete();
    m_valid = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(20);
    chk("post_rst_valid", data_valid, 0);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, CPB);
    wait_idle();
    chk("post_rst_81_valid", data_valid, 1);
    check_front("post_rst_81_data");
    chk("post_rst_81_ferr", framing_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
